// File: rtl/vib_pkg.sv
// Shared constants for the vector input buffer: FSM encodings and width helpers.
// Latency: none (compile-time only).
// Backpressure: not applicable.
package vib_pkg;

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_FULL   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Index width that is never zero, so single-entry selectors still get a bit.
    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/vector_input_buffer_bank.sv
// One operand vector: DEPTH x DATA_W storage, fill pointer and done flag.
// Latency: write lands on the next edge; read port is combinational.
// Backpressure: none; the parent only issues writes the vector can take.
module vector_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  wptr;

    // Fill pointer and done flag; the pointer parks on the last slot instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            done <= 1'b0;
        end else if (clr) begin
            wptr <= '0;
            done <= 1'b0;
        end else if (wr) begin
            if (wptr == LAST_IDX) begin
                done <= 1'b1;
            end else begin
                wptr <= wptr + IDX_W'(1);
            end
        end
    end

    // Storage carries no reset: it is only ever presented after being written.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vector_input_buffer.sv
// Collects NUM_VEC byte-serial operand vectors, then streams them lane-parallel.
// Latency: first element registered one cycle after RD_START is taken in FULL.
// Backpressure: valid/ready on the read port; outputs freeze while not ready.
module vector_input_buffer
    import vib_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int DEPTH         = 8,
    parameter int NUM_VEC       = 2,
    parameter int CLEAR_ON_READ = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clr,
    input  logic                              wr_en,
    input  logic [idx_width(NUM_VEC)-1:0]     wr_sel,
    input  logic [DATA_W-1:0]                 wr_data,
    output logic                              wr_err,
    output logic [NUM_VEC-1:0]                done,
    input  logic                              rd_start,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [NUM_VEC*DATA_W-1:0]         rd_data,
    output logic [idx_width(DEPTH)-1:0]       rd_idx,
    output logic                              rd_last
);

    localparam int SEL_W = idx_width(NUM_VEC);
    localparam int IDX_W = idx_width(DEPTH);
    localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(DEPTH - 2);

    logic [1:0]                state;
    logic [NUM_VEC-1:0]        wr_hit;
    logic [NUM_VEC*DATA_W-1:0] bank_dat;
    logic [IDX_W-1:0]          rd_addr;
    logic                      wr_drop;
    logic                      start;
    logic                      adv;
    logic                      fin;
    logic                      bank_clr;

    // A write is taken only by an in-range, not-yet-full vector outside STREAM.
    always_comb begin
        wr_hit = '0;
        for (int v = 0; v < NUM_VEC; v++) begin
            wr_hit[v] = wr_en && !clr && (state != ST_STREAM) &&
                        (wr_sel == SEL_W'(v)) && !done[v];
        end
    end

    assign wr_drop  = wr_en && !clr && (wr_hit == '0);
    assign start    = (state == ST_FULL) && rd_start && !clr;
    assign adv      = rd_valid && rd_ready && !clr;
    assign fin      = adv && rd_last;
    assign bank_clr = clr || (fin && (CLEAR_ON_READ != 0));
    // Banks are addressed with the index that will be presented after this edge.
    assign rd_addr  = start ? '0 : (rd_idx + IDX_W'(1));

    for (genvar v = 0; v < NUM_VEC; v++) begin : g_bank
        vector_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .IDX_W  (IDX_W)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (bank_clr),
            .wr      (wr_hit[v]),
            .wr_data (wr_data),
            .rd_addr (rd_addr),
            .rd_data (bank_dat[v*DATA_W +: DATA_W]),
            .done    (done[v])
        );
    end

    // Phase control: fill until every vector is done, wait for a start, stream once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
        end else if (clr) begin
            state <= ST_FILL;
        end else begin
            case (state)
                ST_FILL:   if (&done) state <= ST_FULL;
                ST_FULL:   if (rd_start) state <= ST_STREAM;
                ST_STREAM: if (fin) state <= (CLEAR_ON_READ != 0) ? ST_FILL : ST_FULL;
                default:   state <= ST_FILL;
            endcase
        end
    end

    // Dropped-write flag, one cycle after the offending strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_drop;
        end
    end

    // Read-side registers: load on start or accepted beat, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_idx   <= '0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else if (clr) begin
            rd_valid <= 1'b0;
            rd_idx   <= '0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else if (start) begin
            rd_valid <= 1'b1;
            rd_idx   <= '0;
            rd_last  <= 1'b0;
            rd_data  <= bank_dat;
        end else if (adv) begin
            if (rd_last) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
                rd_idx   <= '0;
            end else begin
                rd_idx   <= rd_idx + IDX_W'(1);
                rd_last  <= (rd_idx == PRE_LAST);
                rd_data  <= bank_dat;
            end
        end
    end

endmodule

// File: tb/tb_vector_input_buffer.sv
// Bench for vector_input_buffer: three parameterisations checked against a queue-level model.
// Latency: model updates on each edge, outputs compared on the falling edge.
// Backpressure: read-ready patterns are driven per stream.
module tb_vector_input_buffer;

    localparam int NV  [3] = '{2, 4, 3};
    localparam int DP  [3] = '{8, 5, 2};
    localparam int DW  [3] = '{8, 12, 8};
    localparam int COR [3] = '{0, 1, 0};
    localparam int SW  [3] = '{1, 2, 2};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_clr [3];
    logic        in_wr_en [3];
    logic [1:0]  in_wr_sel [3];
    logic [15:0] in_wr_data [3];
    logic        in_rd_start [3];
    logic        in_rd_ready [3];

    logic [63:0] o_data [3];
    logic [3:0]  o_done [3];
    logic [2:0]  o_idx [3];
    logic        o_valid [3];
    logic        o_last [3];
    logic        o_err [3];

    logic [15:0] d0_data;  logic [1:0] d0_done; logic [2:0] d0_idx;
    logic [47:0] d1_data;  logic [3:0] d1_done; logic [2:0] d1_idx;
    logic [23:0] d2_data;  logic [2:0] d2_done; logic [0:0] d2_idx;

    vector_input_buffer #(.DATA_W(8), .DEPTH(8), .NUM_VEC(2), .CLEAR_ON_READ(0)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(in_clr[0]), .wr_en(in_wr_en[0]),
        .wr_sel(in_wr_sel[0][0:0]), .wr_data(in_wr_data[0][7:0]), .wr_err(o_err[0]),
        .done(d0_done), .rd_start(in_rd_start[0]), .rd_valid(o_valid[0]),
        .rd_ready(in_rd_ready[0]), .rd_data(d0_data), .rd_idx(d0_idx), .rd_last(o_last[0]));

    vector_input_buffer #(.DATA_W(12), .DEPTH(5), .NUM_VEC(4), .CLEAR_ON_READ(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(in_clr[1]), .wr_en(in_wr_en[1]),
        .wr_sel(in_wr_sel[1]), .wr_data(in_wr_data[1][11:0]), .wr_err(o_err[1]),
        .done(d1_done), .rd_start(in_rd_start[1]), .rd_valid(o_valid[1]),
        .rd_ready(in_rd_ready[1]), .rd_data(d1_data), .rd_idx(d1_idx), .rd_last(o_last[1]));

    vector_input_buffer #(.DATA_W(8), .DEPTH(2), .NUM_VEC(3), .CLEAR_ON_READ(0)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(in_clr[2]), .wr_en(in_wr_en[2]),
        .wr_sel(in_wr_sel[2]), .wr_data(in_wr_data[2][7:0]), .wr_err(o_err[2]),
        .done(d2_done), .rd_start(in_rd_start[2]), .rd_valid(o_valid[2]),
        .rd_ready(in_rd_ready[2]), .rd_data(d2_data), .rd_idx(d2_idx), .rd_last(o_last[2]));

    assign o_data[0] = 64'(d0_data);
    assign o_data[1] = 64'(d1_data);
    assign o_data[2] = 64'(d2_data);
    assign o_done[0] = 4'(d0_done);
    assign o_done[1] = 4'(d1_done);
    assign o_done[2] = 4'(d2_done);
    assign o_idx[0]  = d0_idx;
    assign o_idx[1]  = d1_idx;
    assign o_idx[2]  = 3'(d2_idx);

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: phase (0 fill, 1 full, 2 streaming), per-vector element lists.
    int          m_ph [3];
    int          m_cnt [3][4];
    int          m_mem [3][4][8];
    bit          m_valid [3];
    bit          m_last [3];
    bit          m_err [3];
    int          m_idx [3];
    logic [63:0] m_data [3];

    function automatic logic [63:0] beat(input int i, input int e);
        logic [63:0] r;
        r = '0;
        for (int v = 0; v < NV[i]; v++) r |= 64'(m_mem[i][v][e]) << (v * DW[i]);
        return r;
    endfunction

    task automatic model_step(input int i);
        bit all_full;
        bit err_n;
        int sel;
        if (!rst_n || in_clr[i]) begin
            m_ph[i] = 0; m_valid[i] = 0; m_last[i] = 0; m_idx[i] = 0;
            m_data[i] = '0; m_err[i] = 0;
            for (int v = 0; v < 4; v++) m_cnt[i][v] = 0;
            return;
        end
        all_full = 1;
        for (int v = 0; v < NV[i]; v++) if (m_cnt[i][v] != DP[i]) all_full = 0;
        err_n = 0;
        if (in_wr_en[i]) begin
            sel = int'(in_wr_sel[i]) & ((1 << SW[i]) - 1);
            if (m_ph[i] != 2 && sel < NV[i] && m_cnt[i][sel] < DP[i]) begin
                m_mem[i][sel][m_cnt[i][sel]] = int'(in_wr_data[i]) & ((1 << DW[i]) - 1);
                m_cnt[i][sel]++;
            end else begin
                err_n = 1;
            end
        end
        if (m_ph[i] == 0) begin
            if (all_full) m_ph[i] = 1;
        end else if (m_ph[i] == 1) begin
            if (in_rd_start[i]) begin
                m_ph[i] = 2; m_valid[i] = 1; m_idx[i] = 0; m_last[i] = 0;
                m_data[i] = beat(i, 0);
            end
        end else if (in_rd_ready[i]) begin
            if (m_idx[i] == DP[i] - 1) begin
                m_valid[i] = 0; m_last[i] = 0;
                if (COR[i] != 0) begin
                    m_ph[i] = 0;
                    for (int v = 0; v < 4; v++) m_cnt[i][v] = 0;
                end else begin
                    m_ph[i] = 1;
                end
            end else begin
                m_idx[i]++;
                m_data[i] = beat(i, m_idx[i]);
                m_last[i] = (m_idx[i] == DP[i] - 1);
            end
        end
        m_err[i] = err_n;
    endtask

    // Advance the model on every edge and on asynchronous reset.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) model_step(i);
    end

    // Compare every output of every instance against the model on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [3:0] ed;
            ed = '0;
            for (int v = 0; v < NV[i]; v++) ed[v] = (m_cnt[i][v] == DP[i]);
            chk($sformatf("i%0d done", i), 64'(o_done[i]), 64'(ed));
            chk($sformatf("i%0d wr_err", i), 64'(o_err[i]), 64'(m_err[i]));
            chk($sformatf("i%0d rd_valid", i), 64'(o_valid[i]), 64'(m_valid[i]));
            chk($sformatf("i%0d rd_last", i), 64'(o_last[i]), 64'(m_last[i]));
            chk($sformatf("i%0d rd_data", i), o_data[i], m_data[i]);
            if (m_valid[i]) chk($sformatf("i%0d rd_idx", i), 64'(o_idx[i]), 64'(m_idx[i]));
        end
    end

    logic [63:0] q_data [$];
    bit          q_last [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int i, input int sel, input int dat);
        in_wr_en[i] = 1'b1;
        in_wr_sel[i] = 2'(sel);
        in_wr_data[i] = 16'(dat);
        tick();
        in_wr_en[i] = 1'b0;
    endtask

    // Start a stream and collect accepted beats; optionally inject one write at cycle wr_cyc.
    task automatic read_stream(input int i, input logic [31:0] pat, input int wr_cyc);
        int n;
        n = 0;
        q_data.delete();
        q_last.delete();
        in_rd_start[i] = 1'b1;
        tick();
        in_rd_start[i] = 1'b0;
        for (int c = 0; c < 40 && n < DP[i]; c++) begin
            in_rd_ready[i] = (c < 32) ? pat[c] : 1'b1;
            in_wr_en[i] = (c == wr_cyc);
            in_wr_sel[i] = 2'd1;
            in_wr_data[i] = 16'h55;
            @(negedge clk);
            if (o_valid[i] && in_rd_ready[i]) begin
                q_data.push_back(o_data[i]);
                q_last.push_back(o_last[i]);
                n++;
            end
            tick();
        end
        in_rd_ready[i] = 1'b0;
        in_wr_en[i] = 1'b0;
        chk("stream_len", 64'(n), 64'(DP[i]));
    endtask

    task automatic check_ab_beats();
        for (int k = 0; k < q_data.size(); k++) begin
            chk("ab_beat", q_data[k], 64'(((11 + k) << 8) | (1 + k)));
            chk("ab_last", 64'(q_last[k]), 64'(k == 7));
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            in_clr[i] = 0; in_wr_en[i] = 0; in_wr_sel[i] = 0; in_wr_data[i] = 0;
            in_rd_start[i] = 0; in_rd_ready[i] = 0;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_done", 64'(o_done[0]), 64'h0);
        chk("rst_valid", 64'(o_valid[0]), 64'h0);
        chk("rst_data", o_data[0], 64'h0);

        // Fill A = 1..8, B = 11..18, then stream with ready held high.
        for (int e = 0; e < 8; e++) wr(0, 0, 1 + e);
        chk("done_a", 64'(o_done[0]), 64'h1);
        for (int e = 0; e < 8; e++) wr(0, 1, 11 + e);
        chk("done_ab", 64'(o_done[0]), 64'h3);
        tick();
        read_stream(0, 32'hFFFF_FFFF, -1);
        check_ab_beats();

        // Ninth write to a full vector is flagged for exactly one cycle.
        wr(0, 0, 99);
        chk("ninth_err", 64'(o_err[0]), 64'h1);
        tick();
        chk("ninth_err_end", 64'(o_err[0]), 64'h0);

        // Replay under 1,0,0,1 backpressure with a write injected mid-stream.
        read_stream(0, 32'hFFFF_FFF9, 2);
        check_ab_beats();

        // CLR on the third beat together with a write.
        in_rd_start[0] = 1'b1;
        tick();
        in_rd_start[0] = 1'b0;
        in_rd_ready[0] = 1'b1;
        tick();
        tick();
        chk("clr_pre_idx", 64'(o_idx[0]), 64'h2);
        in_clr[0] = 1'b1; in_wr_en[0] = 1'b1; in_wr_sel[0] = 2'd0;
        tick();
        in_clr[0] = 1'b0; in_wr_en[0] = 1'b0; in_rd_ready[0] = 1'b0;
        chk("clr_valid", 64'(o_valid[0]), 64'h0);
        chk("clr_done", 64'(o_done[0]), 64'h0);
        chk("clr_err", 64'(o_err[0]), 64'h0);
        tick();

        // Asynchronous reset in the middle of a fill.
        for (int e = 0; e < 3; e++) wr(0, 0, 40 + e);
        for (int e = 0; e < 8; e++) wr(0, 1, 50 + e);
        chk("mid_done", 64'(o_done[0]), 64'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_done", 64'(o_done[0]), 64'h0);
        chk("async_err", 64'(o_err[0]), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Wide config: early start ignored, interleaved fill, 5-beat stream, clear on read.
        in_rd_start[1] = 1'b1;
        tick();
        in_rd_start[1] = 1'b0;
        chk("early_start", 64'(o_valid[1]), 64'h0);
        for (int e = 0; e < 5; e++) begin
            for (int v = 0; v < 4; v++) begin
                wr(1, v, 100 * v + e + 1);
                if (e == 4) chk("wide_done", 64'(o_done[1]), 64'((1 << (v + 1)) - 1));
            end
        end
        tick();
        read_stream(1, 32'hFFFF_FFFF, -1);
        for (int k = 0; k < q_data.size(); k++) begin
            logic [63:0] exp;
            exp = '0;
            for (int v = 0; v < 4; v++) exp |= 64'(100 * v + k + 1) << (12 * v);
            chk("wide_beat", q_data[k], exp);
            chk("wide_last", 64'(q_last[k]), 64'(k == 4));
        end
        chk("cor_done", 64'(o_done[1]), 64'h0);
        in_rd_start[1] = 1'b1;
        tick();
        in_rd_start[1] = 1'b0;
        chk("cor_start_ignored", 64'(o_valid[1]), 64'h0);
        wr(1, 2, 7);
        chk("cor_refill_err", 64'(o_err[1]), 64'h0);
        tick();

        // Selector beyond NUM_VEC is rejected without touching the others.
        wr(2, 3, 5);
        chk("sel_range_err", 64'(o_err[2]), 64'h1);
        wr(2, 0, 1);
        wr(2, 0, 2);
        chk("small_done", 64'(o_done[2]), 64'h1);
        wr(2, 0, 3);
        chk("small_full_err", 64'(o_err[2]), 64'h1);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
